// File: rtl/rr_mux_reg.sv
// rr_mux_reg: N-channel registered multiplexer with round-robin arbitration
// and valid/ready handshakes on every input channel and on the output.
//
// Optional feature macro: RR_MUX_FORCE_SEL_EN
//   When defined, force_en/force_sel ports exist. While force_en is high, the
//   grant is force_sel if that channel exists and is valid; otherwise there is
//   no grant. Forced grants leave the round-robin pointer untouched.
//   When undefined, the block is pure round-robin.
//
// Pointer r_ptr holds the highest-priority channel. It always stays in
// 0..N-1 because it only ever loads 0 or (grant + 1) with an explicit wrap.
module rr_mux_reg #(
  parameter  int N     = 4,
  parameter  int WIDTH = 8,
  localparam int CW    = $clog2(N)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N*WIDTH-1:0]   in_data,
  input  logic [N-1:0]         in_valid,
  output logic [N-1:0]         in_ready,
  output logic [WIDTH-1:0]     out_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [CW-1:0]        out_ch
`ifdef RR_MUX_FORCE_SEL_EN
  ,
  input  logic                 force_en,
  input  logic [CW-1:0]        force_sel
`endif
);

  // Registered state
  logic [WIDTH-1:0] r_out_data;
  logic [CW-1:0]    r_out_ch;
  logic             r_out_valid;
  logic [CW-1:0]    r_ptr;

  // Combinational arbitration results
  logic             w_load;
  logic             w_rr_found;
  logic [CW-1:0]    w_rr_idx;
  logic             w_gnt_found;
  logic [CW-1:0]    w_gnt_idx;
  logic             w_forced;
  logic [WIDTH-1:0] w_sel_data;
  logic [CW-1:0]    w_ptr_next;
  logic [N-1:0]     w_in_ready;

  // Rotating priority search starting at ptr. Returns {found, index}.
  // The candidate index is ptr+k with a compare-and-subtract wrap, so N
  // need not be a power of two. CW+1 bits are enough since ptr+k <= 2N-2.
  function automatic logic [CW:0] f_rr_pick(
    input logic [N-1:0]  valid,
    input logic [CW-1:0] ptr
  );
    logic [CW:0]   cand;
    logic [CW-1:0] idx;
    logic          found;
    found = 1'b0;
    idx   = {CW{1'b0}};
    for (int k = 0; k < N; k++) begin
      cand = {1'b0, ptr} + (CW+1)'(k);
      if (cand >= (CW+1)'(N)) begin
        cand = cand - (CW+1)'(N);
      end else begin
        cand = cand;
      end
      if (!found && valid[cand[CW-1:0]]) begin
        found = 1'b1;
        idx   = cand[CW-1:0];
      end else begin
        found = found;
      end
    end
    return {found, idx};
  endfunction

  // Load enable: register empty or being drained; never during reset.
  always_comb begin
    w_load = !rst && (!r_out_valid || out_ready);
  end

  // Round-robin candidate from the current pointer.
  always_comb begin
    {w_rr_found, w_rr_idx} = f_rr_pick(in_valid, r_ptr);
  end

  // Final grant: round-robin, optionally overridden by the forced select.
  always_comb begin
    w_forced    = 1'b0;
    w_gnt_found = w_rr_found;
    w_gnt_idx   = w_rr_idx;
`ifdef RR_MUX_FORCE_SEL_EN
    if (force_en) begin
      w_forced    = 1'b1;
      w_gnt_found = 1'b0;
      w_gnt_idx   = force_sel;
      // Only an existing, valid channel can be forced.
      for (int i = 0; i < N; i++) begin
        if ((force_sel == CW'(i)) && in_valid[i]) begin
          w_gnt_found = 1'b1;
        end else begin
          w_gnt_found = w_gnt_found;
        end
      end
    end else begin
      w_forced = 1'b0;
    end
`endif
  end

  // Data mux for the granted channel.
  always_comb begin
    w_sel_data = {WIDTH{1'b0}};
    for (int i = 0; i < N; i++) begin
      if (w_gnt_idx == CW'(i)) begin
        w_sel_data = in_data[i*WIDTH +: WIDTH];
      end else begin
        w_sel_data = w_sel_data;
      end
    end
  end

  // Next pointer: one past the grant, wrapping explicitly at N-1.
  always_comb begin
    if (w_gnt_idx == CW'(N-1)) begin
      w_ptr_next = {CW{1'b0}};
    end else begin
      w_ptr_next = w_gnt_idx + CW'(1);
    end
  end

  // One-hot acknowledge to the granted channel, only when loading.
  always_comb begin
    w_in_ready = {N{1'b0}};
    for (int i = 0; i < N; i++) begin
      w_in_ready[i] = w_load && w_gnt_found && (w_gnt_idx == CW'(i));
    end
  end

  // Output register and round-robin pointer update.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_data  <= {WIDTH{1'b0}};
      r_out_ch    <= {CW{1'b0}};
      r_out_valid <= 1'b0;
      r_ptr       <= {CW{1'b0}};
    end else if (w_load) begin
      if (w_gnt_found) begin
        r_out_data  <= w_sel_data;
        r_out_ch    <= w_gnt_idx;
        r_out_valid <= 1'b1;
        if (!w_forced) begin
          r_ptr <= w_ptr_next;
        end else begin
          r_ptr <= r_ptr;
        end
      end else begin
        // Drained with nothing to refill: empty the register, hold the rest.
        r_out_valid <= 1'b0;
      end
    end else begin
      // Stalled: hold everything.
      r_out_valid <= r_out_valid;
    end
  end

  assign in_ready  = w_in_ready;
  assign out_data  = r_out_data;
  assign out_ch    = r_out_ch;
  assign out_valid = r_out_valid;

endmodule

// File: tb/tb_rr_mux_reg.sv
// Testbench for rr_mux_reg: an N=4 and an N=3 instance driven side by side,
// checked against a reference model that picks grants with modulo rotation.
// Optional macro RR_MUX_FORCE_SEL_EN enables the forced-select steps.
module tb_rr_mux_reg;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        out_ready;
  logic [3:0]  v_in [2];
  logic [7:0]  d_in [2][4];

  logic [31:0] in_data4;
  logic [23:0] in_data3;
  logic [3:0]  in_valid4, in_ready4;
  logic [2:0]  in_valid3, in_ready3;
  logic [7:0]  out_data4, out_data3;
  logic        out_valid4, out_valid3;
  logic [1:0]  out_ch4, out_ch3;
`ifdef RR_MUX_FORCE_SEL_EN
  logic        force_en;
  logic [1:0]  force_sel;
`endif

  assign in_valid4 = v_in[0];
  assign in_valid3 = v_in[1][2:0];
  assign in_data4  = {d_in[0][3], d_in[0][2], d_in[0][1], d_in[0][0]};
  assign in_data3  = {d_in[1][2], d_in[1][1], d_in[1][0]};

  rr_mux_reg #(.N(4), .WIDTH(8)) u_dut4 (
    .clk(clk), .rst(rst),
    .in_data(in_data4), .in_valid(in_valid4), .in_ready(in_ready4),
    .out_data(out_data4), .out_valid(out_valid4), .out_ready(out_ready),
    .out_ch(out_ch4)
`ifdef RR_MUX_FORCE_SEL_EN
    , .force_en(force_en), .force_sel(force_sel)
`endif
  );

  rr_mux_reg #(.N(3), .WIDTH(8)) u_dut3 (
    .clk(clk), .rst(rst),
    .in_data(in_data3), .in_valid(in_valid3), .in_ready(in_ready3),
    .out_data(out_data3), .out_valid(out_valid3), .out_ready(out_ready),
    .out_ch(out_ch3)
`ifdef RR_MUX_FORCE_SEL_EN
    , .force_en(force_en), .force_sel(force_sel)
`endif
  );

  int compared   = 0;
  int mismatched = 0;

  // Reference model state per instance
  int         nch [2] = '{4, 3};
  int         m_ptr [2];
  int         m_ch  [2];
  bit         m_val [2];
  logic [7:0] m_dat [2];

  // First valid channel in the order p, p+1, ... (mod n); -1 if none.
  function automatic int rr_pick(input int n, input int p, input logic [3:0] v);
    for (int k = 0; k < n; k++) begin
      if (v[(p + k) % n] === 1'b1) return (p + k) % n;
    end
    return -1;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: check acknowledges, clock the model, check registered outputs.
  // Called at a falling edge with inputs already driven.
  task automatic step();
    int g   [2];
    bit ld  [2];
    bit frc;
    #1;
    frc = 1'b0;
`ifdef RR_MUX_FORCE_SEL_EN
    frc = force_en;
`endif
    for (int u = 0; u < 2; u++) begin
      ld[u] = !rst && (!m_val[u] || out_ready);
      g[u]  = -1;
      if (ld[u]) begin
        if (frc) begin
`ifdef RR_MUX_FORCE_SEL_EN
          if (int'(force_sel) < nch[u] && v_in[u][force_sel] === 1'b1) g[u] = int'(force_sel);
`endif
        end else begin
          g[u] = rr_pick(nch[u], m_ptr[u], v_in[u]);
        end
      end
    end
    chk("in_ready4", 32'(in_ready4), (g[0] >= 0) ? (32'd1 << g[0]) : 32'd0);
    chk("in_ready3", 32'(in_ready3), (g[1] >= 0) ? (32'd1 << g[1]) : 32'd0);
    @(posedge clk);
    for (int u = 0; u < 2; u++) begin
      if (rst) begin
        m_val[u] = 1'b0; m_dat[u] = 8'h00; m_ch[u] = 0; m_ptr[u] = 0;
      end else if (ld[u]) begin
        if (g[u] >= 0) begin
          m_val[u] = 1'b1;
          m_dat[u] = d_in[u][g[u]];
          m_ch[u]  = g[u];
          if (!frc) m_ptr[u] = (g[u] + 1) % nch[u];
        end else begin
          m_val[u] = 1'b0;
        end
      end
    end
    @(negedge clk);
    chk("out_valid4", 32'(out_valid4), 32'(m_val[0]));
    chk("out_data4",  32'(out_data4),  32'(m_dat[0]));
    chk("out_ch4",    32'(out_ch4),    32'(m_ch[0]));
    chk("out_valid3", 32'(out_valid3), 32'(m_val[1]));
    chk("out_data3",  32'(out_data3),  32'(m_dat[1]));
    chk("out_ch3",    32'(out_ch3),    32'(m_ch[1]));
  endtask

  task automatic set_all(input logic [3:0] v);
    v_in[0] = v;
    v_in[1] = v;
  endtask

  initial begin
    for (int u = 0; u < 2; u++) begin
      m_ptr[u] = 0; m_ch[u] = 0; m_val[u] = 1'b0; m_dat[u] = 8'h00;
      for (int i = 0; i < 4; i++) d_in[u][i] = 8'h10 + 8'(i * 8'h11);
    end
    rst       = 1'b1;
    out_ready = 1'b1;
    set_all(4'hF);
`ifdef RR_MUX_FORCE_SEL_EN
    force_en  = 1'b0;
    force_sel = 2'd0;
`endif
    @(negedge clk);

    // Reset with all channels valid
    repeat (2) step();
    rst = 1'b0;

    // Round robin, all valid, data 0x10/0x21/0x32/0x43
    repeat (8) step();

    // Sparse: channels 3 and 1 only (channel 1 only for N=3)
    v_in[0] = 4'b1010;
    v_in[1] = 4'b0010;
    repeat (4) step();

    // Wrap: grant channel 2 so ptr becomes 3 (N=4), then all valid
    set_all(4'b0100);
    step();
    set_all(4'hF);
    repeat (3) step();

    // Backpressure for 3 cycles, then release
    out_ready = 1'b0;
    repeat (3) step();
    out_ready = 1'b1;
    repeat (4) step();

    // Drain to empty, then refill
    set_all(4'h0);
    repeat (2) step();

`ifdef RR_MUX_FORCE_SEL_EN
    // Forced select of channel 2 with all valid, then with channel 2 idle
    set_all(4'hF);
    force_en  = 1'b1;
    force_sel = 2'd2;
    repeat (4) step();
    set_all(4'b1011);
    repeat (2) step();
    force_sel = 2'd3;
    set_all(4'hF);
    repeat (2) step();
    force_en = 1'b0;
    repeat (3) step();
`endif

    // Randomized traffic with occasional backpressure and resets
    for (int t = 0; t < 400; t++) begin
      for (int u = 0; u < 2; u++) begin
        v_in[u] = 4'($urandom);
        for (int i = 0; i < 4; i++) d_in[u][i] = 8'($urandom);
      end
      out_ready = ($urandom_range(0, 9) < 7);
      rst       = ($urandom_range(0, 49) == 0);
`ifdef RR_MUX_FORCE_SEL_EN
      force_en  = ($urandom_range(0, 7) == 0);
      force_sel = 2'($urandom);
`endif
      step();
    end
    rst = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
